// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flagged synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  // Count must hold 0..DEPTH inclusive, hence one bit beyond the address.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (distributed RAM).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, programmable almost flags, error pulses
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2,
  parameter int FWFT         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = cnt_width(ADDR_WIDTH);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic                wr_acc, rd_acc;
  logic [WIDTH-1:0]    rdata;

  // Pointer MSB is the wrap bit: same low bits with differing MSBs means full.
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign almost_full  = (count_q >= CW'(AFULL_LEVEL));
  assign almost_empty = (count_q <= CW'(AEMPTY_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = write_enable & ~full;
  assign rd_acc = read_enable & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    ovf_d   = write_enable & full;
    udf_d   = read_enable & empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  generate
    if (FWFT == FIFO_MODE_STD) begin : g_std
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= rdata;
      end
      assign data_out = dout_q;
    end else if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is visible whenever the FIFO holds data; undefined while empty.
      assign data_out = rdata;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-read and an FWFT instance with identical traffic and checks
// both against a queue-based model of the FIFO every cycle.
module tb_sync_fifo_flags;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFL = 14;
  localparam int AEL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] din = '0;
  logic we = 1'b0, re = 1'b0;

  logic [W-1:0] dout0, dout1;
  logic full0, empty0, af0, ae0, ovf0, udf0;
  logic full1, empty1, af1, ae1, ovf1, udf1;
  logic [AW:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout = '0;
  logic exp_ovf = 1'b0, exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(W), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFL),
                    .AEMPTY_LEVEL(AEL), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .data_in(din), .write_enable(we), .read_enable(re),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_flags #(.WIDTH(W), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFL),
                    .AEMPTY_LEVEL(AEL), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .data_in(din), .write_enable(we), .read_enable(re),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std.count", 32'(cnt0), n);
    chk("std.full", 32'(full0), 32'(n == DEPTH));
    chk("std.empty", 32'(empty0), 32'(n == 0));
    chk("std.afull", 32'(af0), 32'(n >= AFL));
    chk("std.aempty", 32'(ae0), 32'(n <= AEL));
    chk("std.overflow", 32'(ovf0), 32'(exp_ovf));
    chk("std.underflow", 32'(udf0), 32'(exp_udf));
    chk("std.data_out", 32'(dout0), 32'(exp_dout));
    chk("fwft.count", 32'(cnt1), n);
    chk("fwft.full", 32'(full1), 32'(n == DEPTH));
    chk("fwft.empty", 32'(empty1), 32'(n == 0));
    chk("fwft.afull", 32'(af1), 32'(n >= AFL));
    chk("fwft.aempty", 32'(ae1), 32'(n <= AEL));
    chk("fwft.overflow", 32'(ovf1), 32'(exp_ovf));
    chk("fwft.underflow", 32'(udf1), 32'(exp_udf));
    if (n > 0) chk("fwft.data_out", 32'(dout1), 32'(q[0]));
  endtask

  // One clock: apply request, advance the model on the edge, check just after.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    logic was_full, was_empty;
    we = w; re = r; din = d;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    exp_ovf = w && was_full;
    exp_udf = r && was_empty;
    if (r && !was_empty) exp_dout = q.pop_front();
    if (w && !was_full) q.push_back(d);
    #1;
    check_all();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Two writes and a read: A1 emerges one cycle after the read request.
    step(1, 0, 8'hA1);
    step(1, 0, 8'hB2);
    step(0, 1, 8'h00);
    chk("t1.data_out", 32'(dout0), 32'h0A1);
    step(0, 1, 8'h00);

    // Fill with 00..0F, then one write too many.
    for (int i = 0; i < DEPTH; i++) step(1, 0, W'(i));
    step(1, 0, 8'hEE);
    chk("t2.overflow", 32'(ovf0), 32'h1);
    step(0, 0, 8'h00);

    // Drain in order, then one read too many; data_out must hold 0F.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
    chk("t3.last", 32'(dout0), 32'h0F);
    step(0, 1, 8'h00);
    chk("t3.underflow", 32'(udf0), 32'h1);
    chk("t3.hold", 32'(dout0), 32'h0F);

    // Hold at 8 with concurrent traffic; pointers wrap past 31.
    for (int i = 0; i < 8; i++) step(1, 0, W'($urandom));
    for (int i = 0; i < 40; i++) step(1, 1, W'($urandom));
    chk("t4.count", 32'(cnt0), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);

    // Full with both enables: read wins, write rejected.
    for (int i = 0; i < DEPTH; i++) step(1, 0, W'($urandom));
    step(1, 1, 8'h55);
    chk("t5.count15", 32'(cnt0), 32'd15);
    for (int i = 0; i < 15; i++) step(0, 1, 8'h00);
    // Empty with both enables: write wins, read rejected.
    step(1, 1, 8'h66);
    chk("t5.count1", 32'(cnt0), 32'd1);
    step(0, 1, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), W'($urandom));

    // FWFT: C3 visible the cycle after writing it into an empty FIFO.
    do_reset();
    step(1, 0, 8'hC3);
    chk("t6.fwft", 32'(dout1), 32'h0C3);
    for (int i = 0; i < 5; i++) step(1, 0, W'($urandom));
    #2;
    rst = 1'b1;
    #1;
    chk("t6.rst_empty", 32'(empty0), 32'h1);
    chk("t6.rst_count", 32'(cnt1), 32'h0);
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
